// File: rtl/mux_accum_pkg.sv
// rtl/mux_accum_pkg.sv - shared types and default widths for the mux accumulate sequencer
package mux_accum_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mux_accum_ctrl_down_counter.sv
// rtl/mux_accum_ctrl_down_counter.sv - loadable down counter tracking remaining accumulations
module down_counter
  import mux_accum_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         le_one
);

  // Load takes priority over decrement; the sequencer never asserts both together.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec) begin
      value <= value - 1'b1;
    end
  end

  // Zero or one remaining: the last accumulation is in progress (or none is needed).
  assign le_one = (value <= W'(1));

endmodule

// File: rtl/mux_accum_ctrl.sv
// rtl/mux_accum_ctrl.sv - drives the operand mux select, loads a, accumulates b, hands off the sum
module mux_accum_ctrl
  import mux_accum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] mux_out,
  output logic             sel_mux,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow
);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH:0]     sum;
  logic [CNT_W-1:0]   remaining;
  logic               remaining_le_one;
  logic               cnt_load;
  logic               cnt_dec;

  down_counter #(
    .W (CNT_W)
  ) u_down_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (count),
    .dec        (cnt_dec),
    .value      (remaining),
    .le_one     (remaining_le_one)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Moore outputs; the mux select depends on state only.
  always_comb begin
    state_next   = state;
    sel_mux      = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          cnt_load   = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (remaining == '0) begin
          state_next = DONE;
        end else begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        sel_mux = 1'b1;
        cnt_dec = 1'b1;
        if (remaining_le_one) begin
          state_next = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One bit wider than the data so the carry-out is visible while the sum wraps.
  assign sum = {1'b0, acc} + {1'b0, mux_out};

  // Accumulator and sticky overflow; both hold through DONE and IDLE until the next start.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            overflow <= 1'b0;
          end
        end
        LOAD: begin
          acc <= mux_out;
        end
        ACCUM: begin
          acc      <= sum[WIDTH-1:0];
          overflow <= overflow | sum[WIDTH];
        end
        default: begin
        end
      endcase
    end
  end

  assign result = acc;

endmodule

// File: tb/tb_mux_accum_ctrl.sv
// tb/tb_mux_accum_ctrl.sv - directed self-checking bench for mux_accum_ctrl
module tb_mux_accum_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  count;
  logic [15:0] mux_out;
  logic        sel_mux;
  logic        busy;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        overflow;
  logic [15:0] a;
  logic [15:0] b;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Operand mux model: purely combinational, zero latency.
  assign mux_out = sel_mux ? b : a;

  mux_accum_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .count        (count),
    .mux_out      (mux_out),
    .sel_mux      (sel_mux),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the LOAD cycle (n=1); returns the cycle index where result_valid is seen.
  task automatic run_to_valid(input int bound, output int n, output int ones, output logic sel_load);
    n = 1;
    ones = 0;
    sel_load = sel_mux;
    while (!result_valid && n < bound) begin
      if (sel_mux) ones++;
      step();
      n++;
    end
  endtask

  task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic [7:0] cv);
    a = av;
    b = bv;
    count = cv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (result_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", result_valid); else pass_cnt++;
    total_cnt++; if (result !== 16'h0000) $display("FAIL reset_result got %h want 0000", result); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else pass_cnt++;
    total_cnt++; if (sel_mux !== 1'b0) $display("FAIL reset_sel got %b want 0", sel_mux); else pass_cnt++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int n, ones;
    logic sl;
    launch(16'h0005, 16'h0003, 8'd4);
    count = 8'd9;
    total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else pass_cnt++;
    run_to_valid(20, n, ones, sl);
    total_cnt++; if (sl !== 1'b0) $display("FAIL basic_sel_load got %b want 0", sl); else pass_cnt++;
    total_cnt++; if (n != 6) $display("FAIL basic_latency got %0d want 6", n); else pass_cnt++;
    total_cnt++; if (ones != 4) $display("FAIL basic_sel_cycles got %0d want 4", ones); else pass_cnt++;
    total_cnt++; if (result !== 16'h0011) $display("FAIL basic_result got %h want 0011", result); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL basic_overflow got %b want 0", overflow); else pass_cnt++;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (result_valid !== 1'b0) $display("FAIL basic_valid_after got %b want 0", result_valid); else pass_cnt++;
    total_cnt++; if (result !== 16'h0011) $display("FAIL basic_result_hold got %h want 0011", result); else pass_cnt++;
  endtask

  task automatic test_zero_count();
    int n, ones;
    logic sl;
    launch(16'h1234, 16'h5555, 8'd0);
    run_to_valid(20, n, ones, sl);
    total_cnt++; if (n != 2) $display("FAIL zero_latency got %0d want 2", n); else pass_cnt++;
    total_cnt++; if (ones != 0 || sl !== 1'b0) $display("FAIL zero_sel got %0d want 0", ones); else pass_cnt++;
    total_cnt++; if (result !== 16'h1234) $display("FAIL zero_result got %h want 1234", result); else pass_cnt++;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int n, ones;
    logic sl;
    launch(16'hFFF0, 16'h0010, 8'd2);
    run_to_valid(20, n, ones, sl);
    total_cnt++; if (n != 4) $display("FAIL ovf_latency got %0d want 4", n); else pass_cnt++;
    total_cnt++; if (result !== 16'h0010) $display("FAIL ovf_result got %h want 0010", result); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else pass_cnt++;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_hold got %b want 1", overflow); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n, ones;
    logic sl;
    launch(16'h0007, 16'h0001, 8'd3);
    total_cnt++; if (overflow !== 1'b0) $display("FAIL bp_ovf_cleared got %b want 0", overflow); else pass_cnt++;
    run_to_valid(20, n, ones, sl);
    total_cnt++; if (n != 5) $display("FAIL bp_latency got %0d want 5", n); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      result_ready = 1'b0;
      start = (i == 2);
      count = 8'd5;
      total_cnt++; if (result_valid !== 1'b1) $display("FAIL bp_valid_%0d got %b want 1", i, result_valid); else pass_cnt++;
      total_cnt++; if (result !== 16'h000A) $display("FAIL bp_result_%0d got %h want 000a", i, result); else pass_cnt++;
      step();
    end
    start = 1'b0;
    total_cnt++; if (result_valid !== 1'b1) $display("FAIL bp_valid_end got %b want 1", result_valid); else pass_cnt++;
    result_ready = 1'b1;
    start = 1'b1;
    step();
    result_ready = 1'b0;
    start = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL bp_busy_release got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (result_valid !== 1'b0) $display("FAIL bp_valid_release got %b want 0", result_valid); else pass_cnt++;
    step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL bp_start_ignored got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_ready_early();
    int n, ones;
    logic sl;
    result_ready = 1'b1;
    launch(16'h0002, 16'h0003, 8'd1);
    run_to_valid(20, n, ones, sl);
    total_cnt++; if (n != 3) $display("FAIL early_latency got %0d want 3", n); else pass_cnt++;
    total_cnt++; if (result !== 16'h0005) $display("FAIL early_result got %h want 0005", result); else pass_cnt++;
    step();
    total_cnt++; if (result_valid !== 1'b0) $display("FAIL early_valid_one_cycle got %b want 0", result_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL early_busy got %b want 0", busy); else pass_cnt++;
    result_ready = 1'b0;
  endtask

  task automatic test_max_count();
    int n, ones;
    logic sl;
    launch(16'h0000, 16'h0001, 8'd255);
    run_to_valid(300, n, ones, sl);
    total_cnt++; if (n != 257) $display("FAIL max_latency got %0d want 257", n); else pass_cnt++;
    total_cnt++; if (ones != 255) $display("FAIL max_sel_cycles got %0d want 255", ones); else pass_cnt++;
    total_cnt++; if (result !== 16'h00FF) $display("FAIL max_result got %h want 00ff", result); else pass_cnt++;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic test_reset_mid_accum();
    int n, ones;
    logic sl;
    launch(16'h0001, 16'h0002, 8'd10);
    step();
    step();
    step();
    total_cnt++; if (sel_mux !== 1'b1) $display("FAIL rst_mid_in_accum got %b want 1", sel_mux); else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (result_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", result_valid); else pass_cnt++;
    total_cnt++; if (result !== 16'h0000) $display("FAIL rst_mid_acc got %h want 0000", result); else pass_cnt++;
    total_cnt++; if (sel_mux !== 1'b0) $display("FAIL rst_mid_sel got %b want 0", sel_mux); else pass_cnt++;
    step();
    total_cnt++; if (result_valid !== 1'b0) $display("FAIL rst_mid_no_pulse got %b want 0", result_valid); else pass_cnt++;
    launch(16'h0004, 16'h0006, 8'd2);
    run_to_valid(20, n, ones, sl);
    total_cnt++; if (n != 4) $display("FAIL rst_fresh_latency got %0d want 4", n); else pass_cnt++;
    total_cnt++; if (result !== 16'h0010) $display("FAIL rst_fresh_result got %h want 0010", result); else pass_cnt++;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    count = 8'd0;
    result_ready = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    test_reset();
    test_basic();
    test_zero_count();
    test_overflow();
    test_backpressure();
    test_ready_early();
    test_max_count();
    test_reset_mid_accum();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mux_accum_ctrl.md
# mux_accum_ctrl

Sequencing stage wrapped around the datapath's 16-bit two-input operand mux. It drives the mux select, consumes the selected 16-bit word, loads an initial value from input a, and then accumulates input b a programmed number of times. It presents the sum to the downstream consumer through a valid/ready handshake. It sits between the operand mux and the result register/display logic.

## Interface
Parameters:
- WIDTH, 16, data width; matches the mux data width.
- CNT_W, 8, width of the repeat count.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- count  input  CNT_W  number of b accumulations; captured with start.
- mux_out  input  WIDTH  selected word returned from the operand mux.
- sel_mux  output  1  mux select: 0 selects a, 1 selects b.
- busy  output  1  high in every state except IDLE.
- result  output  WIDTH  accumulator value.
- result_valid  output  1  high in DONE.
- result_ready  input  1  consumer accepts the result.
- overflow  output  1  sticky unsigned carry-out flag for the current operation.

## Operation
- FSM states are IDLE, LOAD, ACCUM, and DONE.
- IDLE:
  - sel_mux=0, busy=0, result_valid=0.
  - When start=1, capture count into remaining, clear overflow, and go to LOAD.
- LOAD:
  - sel_mux=0 and acc <= mux_out.
  - If remaining==0, go to DONE; otherwise go to ACCUM.
- ACCUM:
  - sel_mux=1.
  - acc <= (acc + mux_out) mod 2^WIDTH.
  - overflow <= overflow | carry-out.
  - remaining <= remaining-1.
  - When remaining==1, go to DONE.
- DONE:
  - result_valid=1, and result holds acc stable.
  - When result_ready=1, go to IDLE. acc and overflow hold until the next start.
- start outside IDLE is ignored; there is no queueing.
- Changing count outside IDLE has no effect.
- sel_mux is a Moore output, decoded from state only: 1 in ACCUM, 0 otherwise.
- Width rule: the adder is WIDTH+1 bits wide. Bit WIDTH feeds overflow, and the sum wraps.

## Timing
- Reset values: state=IDLE, acc=0, remaining=0, overflow=0, sel_mux=0, busy=0, result_valid=0, result=0.
- Reset asserted in any state returns the block to IDLE on that edge. Any in-flight result is discarded with no valid pulse.
- Latency, counting start sampled at edge t:
  - LOAD occupies cycle t+1.
  - ACCUM occupies cycles t+2 through t+1+count.
  - result_valid rises in cycle t+2+count.
- count=0 gives a latency of 2 cycles, with result = a.
- count=2^CNT_W-1 gives the maximum run; no counter wrap is permitted.
- busy rises the cycle after start is sampled and falls the cycle after the DONE handshake.
- Handshake:
  - result_valid stays high until result_ready is sampled high.
  - result_ready is allowed high before valid; the transfer completes in the first DONE cycle.
  - result_ready=1 in the same cycle start=1 arrives in DONE: only the transfer occurs, and start is ignored.
- mux_out must be stable before each rising edge in LOAD and ACCUM. The block assumes the mux is purely combinational, with zero cycles of mux latency.

## Structure
- Shared package mux_accum_pkg contains:
  - The state typedef: enum logic [1:0] {IDLE, LOAD, ACCUM, DONE}.
  - The default WIDTH and CNT_W constants.
- One natural sub-module, down_counter:
  - Inputs: load, load value, and decrement enable.
  - Outputs: the count and a flag for zero or one remaining.
- Everything else (FSM, accumulator, overflow flag) stays in mux_accum_ctrl.
- The top-level integration instantiates the existing 2:1 mux beside this block, wiring sel_mux and mux_out.

## Test plan
- Basic run: a=0x0005, b=0x0003, count=4, start pulsed.
  - result_valid rises 6 cycles after start.
  - result=0x0011, overflow=0.
  - sel_mux is 0 in LOAD, and 1 for exactly 4 cycles.
- Zero count: a=0x1234, count=0.
  - result=0x1234 after 2 cycles.
  - sel_mux is never 1.
- Overflow wrap: a=0xFFF0, b=0x0010, count=2.
  - result=0x0010, overflow=1.
- Backpressure: result_ready held low for 5 cycles after valid.
  - result_valid and result stay stable.
  - A start pulse during DONE is ignored.
  - Releasing ready returns the block to IDLE, with busy=0 on the next cycle.
- Reset mid-ACCUM: count=10, reset asserted in the 3rd ACCUM cycle.
  - Next cycle: state IDLE, acc=0, busy=0, result_valid=0.
  - A fresh run then produces correct results.
